soft_stop: RTL and testbench
============================

SOFT_STOP -- requirements
Module: soft_stop

Interface
REQ-001 Parameters SHALL be: DUTY_W, default 8, duty-select width; TS_W, default 10, period-counter width; CONST_TS, default 10, clocks per switching period; NUM_CYCLES, default 5, periods per duty step; STEP, default 1, duty decrement per step.
REQ-002 Ports SHALL be, clock and reset first:
- i_clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- i_stop  input  1  level stop request.
- i_duty_start  input  DUTY_W  duty in force at stop time.
- i_fault  input  1  fast-stop request.
- o_duty_sel  output  DUTY_W  ramped duty select.
- o_enable  output  1  power-stage enable.
- o_busy  output  1  ramp in progress.
- o_done  output  1  ramp-down complete.
REQ-003 The block SHALL use one clock, i_clk; reset SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, RAMP and DONE, with all outputs registered.
REQ-005 IDLE behaviour SHALL be:
- duty register loads i_duty_start every clock.
- o_duty_sel shows that load one cycle later.
- o_enable = (duty register != 0).
- o_busy = 0, o_done = 0.
REQ-006 IDLE with i_stop=1 SHALL take one of two paths:
- i_duty_start != 0: load ts_cnt=CONST_TS-1 and cyc_cnt=NUM_CYCLES-1, enter RAMP next cycle.
- i_duty_start == 0: enter DONE directly.
REQ-007 RAMP counting SHALL be:
- ts_cnt decrements every clock; at 0 it reloads CONST_TS-1 and asserts a one-clock period tick.
- cyc_cnt decrements on each tick; at 0 on a tick it reloads NUM_CYCLES-1 and asserts a step.
REQ-008 On a step, duty SHALL become duty-STEP when duty > STEP, else 0 (saturating, no wrap).
REQ-009 Steps SHALL occur every CONST_TS*NUM_CYCLES clocks; the first step lands CONST_TS*NUM_CYCLES clocks after RAMP entry.
REQ-010 In RAMP, o_busy SHALL be 1 and o_enable SHALL be 1 while duty != 0.
REQ-011 When a step yields duty 0, the FSM SHALL enter DONE; o_duty_sel=0, o_enable=0, o_busy=0 and o_done=1 SHALL appear in the same cycle.
REQ-012 Deasserting i_stop during RAMP SHALL NOT abort the ramp.
REQ-013 Changes on i_duty_start during RAMP SHALL be ignored.
REQ-014 DONE SHALL hold o_done=1, o_duty_sel=0 and o_enable=0 until i_stop=0, then return to IDLE next cycle.
REQ-015 A CONST_TS or NUM_CYCLES value of 0 SHALL be treated as 1.

Reset
REQ-016 Reset SHALL force the FSM to IDLE, clear all counters and the duty register, and drive every output to 0.
REQ-017 Reset asserted mid-RAMP SHALL abandon the ramp immediately; after release the block SHALL behave as from power-up.

Configuration
REQ-018 With SOFT_STOP_FAULT_EN defined, i_fault=1 in any state SHALL, at the next edge, force duty 0, o_enable=0 and entry to DONE (o_done=1).
REQ-019 i_fault SHALL take priority over i_stop and over a same-cycle step.
REQ-020 Without SOFT_STOP_FAULT_EN, the i_fault port SHALL remain present and be ignored.

Structure
REQ-021 Package smps_pkg SHALL hold the FSM state enum and the default CONST_TS, NUM_CYCLES and STEP constants, shared with soft_start.
REQ-022 Sub-module soft_stop_tick SHALL implement the ts_cnt/cyc_cnt chain and output a one-clock step pulse.

Verification
REQ-023 The bench SHALL cover these directed scenarios (defaults; T = first RAMP cycle):
- Nominal ramp: i_duty_start=4, i_stop held 1 -> o_duty_sel is 4 in T..T+49, 3 from T+50, 2 from T+100, 1 from T+150, 0 from T+200 with o_done=1, o_enable=0.
- Saturating step: STEP=3, i_duty_start=4 -> duty 4, then 1 at T+50, then 0 at T+100; never wraps.
- Zero start: i_duty_start=0, i_stop=1 -> DONE one cycle later, o_busy never 1.
- Stop release: i_stop dropped at T+20 -> ramp completes at T+200; i_stop then held 0 -> IDLE one cycle later.
- Reset abort: reset pulsed at T+75 -> all outputs 0 asynchronously; after release, IDLE tracks i_duty_start.
- Fault: SOFT_STOP_FAULT_EN defined, i_fault=1 at T+30 -> next cycle o_duty_sel=0, o_done=1; macro undefined -> ramp unaffected.

Source files
------------

// File: rtl/smps_pkg.sv
// Types and default timing constants shared by the soft_stop and soft_start ramp controllers.
package smps_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } ramp_state_t;

    localparam int DEF_CONST_TS   = 10;
    localparam int DEF_NUM_CYCLES = 5;
    localparam int DEF_STEP       = 1;

    // A count of zero would stall the timers forever; run it as a count of one.
    function automatic int eff_count(input int n);
        return (n <= 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/soft_stop_tick.sv
// Ramp timebase: a switching-period down-counter chained into a periods-per-step down-counter.
module soft_stop_tick
    import smps_pkg::*;
#(
    parameter int TS_W       = 10,
    parameter int CONST_TS   = DEF_CONST_TS,
    parameter int NUM_CYCLES = DEF_NUM_CYCLES
) (
    input  logic i_clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_run,
    output logic o_step
);

    localparam int TS_EFF  = eff_count(CONST_TS);
    localparam int CYC_EFF = eff_count(NUM_CYCLES);
    localparam int CYC_W   = (CYC_EFF > 1) ? $clog2(CYC_EFF) : 1;

    localparam logic [TS_W-1:0]  TS_LOAD  = TS_W'(TS_EFF - 1);
    localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(CYC_EFF - 1);

    logic [TS_W-1:0]  ts_cnt;
    logic [CYC_W-1:0] cyc_cnt;
    logic             tick;

    assign tick   = i_run && (ts_cnt == '0);
    assign o_step = tick && (cyc_cnt == '0);

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            ts_cnt  <= '0;
            cyc_cnt <= '0;
        end else if (i_load) begin
            ts_cnt  <= TS_LOAD;
            cyc_cnt <= CYC_LOAD;
        end else if (i_run) begin
            ts_cnt <= tick ? TS_LOAD : ts_cnt - TS_W'(1);
            if (tick)
                cyc_cnt <= (cyc_cnt == '0) ? CYC_LOAD : cyc_cnt - CYC_W'(1);
        end
    end

endmodule

// File: rtl/soft_stop.sv
// Soft-stop controller: on a stop request, ramps the duty select down to zero in timed steps.
// Define SOFT_STOP_FAULT_EN to let i_fault force an immediate stop; otherwise i_fault is ignored.
//
// state | meaning
// IDLE  | duty tracks i_duty_start, waiting for i_stop
// RAMP  | duty stepped down every CONST_TS*NUM_CYCLES clocks
// DONE  | duty 0, stage disabled, held until i_stop drops
module soft_stop
    import smps_pkg::*;
#(
    parameter int DUTY_W     = 8,
    parameter int TS_W       = 10,
    parameter int CONST_TS   = DEF_CONST_TS,
    parameter int NUM_CYCLES = DEF_NUM_CYCLES,
    parameter int STEP       = DEF_STEP
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              i_stop,
    input  logic [DUTY_W-1:0] i_duty_start,
    input  logic              i_fault,
    output logic [DUTY_W-1:0] o_duty_sel,
    output logic              o_enable,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(STEP);

    ramp_state_t       state, next_state;
    logic [DUTY_W-1:0] duty, next_duty;
    logic              load, run, step, fault_hit;

`ifdef SOFT_STOP_FAULT_EN
    assign fault_hit = i_fault;
`else
    logic unused_fault;
    assign unused_fault = i_fault;
    assign fault_hit    = 1'b0;
`endif

    assign run = (state == ST_RAMP);

    soft_stop_tick #(
        .TS_W       (TS_W),
        .CONST_TS   (CONST_TS),
        .NUM_CYCLES (NUM_CYCLES)
    ) u_tick (
        .i_clk  (i_clk),
        .reset  (reset),
        .i_load (load),
        .i_run  (run),
        .o_step (step)
    );

    always_comb begin
        next_state = state;
        next_duty  = duty;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                next_duty = i_duty_start;
                if (i_stop) begin
                    if (i_duty_start != '0) begin
                        next_state = ST_RAMP;
                        load       = 1'b1;
                    end else begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_RAMP: begin
                if (step) begin
                    next_duty = (duty > STEP_D) ? duty - STEP_D : '0;
                    if (next_duty == '0)
                        next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_duty = '0;
                if (!i_stop)
                    next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
                next_duty  = '0;
            end
        endcase
        // A fault overrides stop requests and any step landing in the same cycle.
        if (fault_hit) begin
            next_state = ST_DONE;
            next_duty  = '0;
            load       = 1'b0;
        end
    end

    // Flags come from the next-state values so they line up with the duty register.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            duty     <= '0;
            o_enable <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state    <= next_state;
            duty     <= next_duty;
            o_enable <= (next_duty != '0);
            o_busy   <= (next_state == ST_RAMP);
            o_done   <= (next_state == ST_DONE);
        end
    end

    assign o_duty_sel = duty;

endmodule

// File: tb/tb_soft_stop.sv
// Directed bench for soft_stop: default-step and STEP=3 instances share one stimulus sequence.
module tb_soft_stop;

    logic       i_clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_stop = 1'b0;
    logic [7:0] i_duty_start = 8'd0;
    logic       i_fault = 1'b0;

    logic [7:0] d1_duty, d2_duty;
    logic       d1_en, d1_busy, d1_done;
    logic       d2_en, d2_busy, d2_done;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    soft_stop dut1 (
        .i_clk        (i_clk),
        .reset        (reset),
        .i_stop       (i_stop),
        .i_duty_start (i_duty_start),
        .i_fault      (i_fault),
        .o_duty_sel   (d1_duty),
        .o_enable     (d1_en),
        .o_busy       (d1_busy),
        .o_done       (d1_done)
    );

    soft_stop #(.STEP(3)) dut2 (
        .i_clk        (i_clk),
        .reset        (reset),
        .i_stop       (i_stop),
        .i_duty_start (i_duty_start),
        .i_fault      (i_fault),
        .o_duty_sel   (d2_duty),
        .o_enable     (d2_en),
        .o_busy       (d2_busy),
        .o_done       (d2_done)
    );

    task automatic adv(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1;
        chk("rst_duty", 32'(d1_duty), 0);
        chk("rst_en",   32'(d1_en),   0);
        chk("rst_busy", 32'(d1_busy), 0);
        chk("rst_done", 32'(d1_done), 0);
        @(negedge i_clk);
        reset = 1'b0;

        // Nominal ramp from 4 (dut1 STEP=1, dut2 STEP=3)
        i_duty_start = 8'd4;
        adv(2);
        chk("idle_duty", 32'(d1_duty), 4);
        chk("idle_en",   32'(d1_en),   1);
        chk("idle_busy", 32'(d1_busy), 0);
        i_stop = 1'b1;
        adv(1);                                   // T
        chk("T_busy", 32'(d1_busy), 1);
        chk("T_duty", 32'(d1_duty), 4);
        adv(10);                                  // T+10
        i_duty_start = 8'd9;
        adv(39);                                  // T+49
        chk("T49_d1", 32'(d1_duty), 4);
        chk("T49_d2", 32'(d2_duty), 4);
        adv(1);                                   // T+50
        chk("T50_d1", 32'(d1_duty), 3);
        chk("T50_d2", 32'(d2_duty), 1);
        chk("T50_d2_busy", 32'(d2_busy), 1);
        adv(49);                                  // T+99
        chk("T99_d2", 32'(d2_duty), 1);
        adv(1);                                   // T+100
        chk("T100_d1",      32'(d1_duty), 2);
        chk("T100_d2",      32'(d2_duty), 0);
        chk("T100_d2_done", 32'(d2_done), 1);
        chk("T100_d2_en",   32'(d2_en),   0);
        chk("T100_d2_busy", 32'(d2_busy), 0);
        adv(50);                                  // T+150
        chk("T150_d1", 32'(d1_duty), 1);
        adv(49);                                  // T+199
        chk("T199_d1",   32'(d1_duty), 1);
        chk("T199_en",   32'(d1_en),   1);
        chk("T199_busy", 32'(d1_busy), 1);
        adv(1);                                   // T+200
        chk("T200_d1",   32'(d1_duty), 0);
        chk("T200_done", 32'(d1_done), 1);
        chk("T200_en",   32'(d1_en),   0);
        chk("T200_busy", 32'(d1_busy), 0);
        adv(1);
        chk("done_hold", 32'(d1_done), 1);
        i_stop = 1'b0;
        adv(1);
        chk("back_idle_done", 32'(d1_done), 0);
        chk("back_idle_busy", 32'(d1_busy), 0);
        adv(1);
        chk("idle_tracks_new", 32'(d1_duty), 9);
        chk("idle_tracks_en",  32'(d1_en),   1);

        // Zero start goes straight to DONE
        i_duty_start = 8'd0;
        adv(1);
        chk("zero_idle_en", 32'(d1_en), 0);
        i_stop = 1'b1;
        adv(1);
        chk("zero_done", 32'(d1_done), 1);
        chk("zero_busy", 32'(d1_busy), 0);
        chk("zero_duty", 32'(d1_duty), 0);
        i_stop = 1'b0;
        adv(1);
        chk("zero_release", 32'(d1_done), 0);

        // Stop released mid-ramp: ramp still completes
        i_duty_start = 8'd4;
        adv(1);
        i_stop = 1'b1;
        adv(1);                                   // T
        adv(20);                                  // T+20
        i_stop = 1'b0;
        chk("rel_T20_busy", 32'(d1_busy), 1);
        adv(179);                                 // T+199
        chk("rel_T199_duty", 32'(d1_duty), 1);
        chk("rel_T199_busy", 32'(d1_busy), 1);
        adv(1);                                   // T+200
        chk("rel_T200_done", 32'(d1_done), 1);
        chk("rel_T200_duty", 32'(d1_duty), 0);
        adv(1);
        chk("rel_idle_done", 32'(d1_done), 0);
        chk("rel_idle_busy", 32'(d1_busy), 0);

        // Reset mid-ramp
        i_duty_start = 8'd4;
        adv(1);
        i_stop = 1'b1;
        adv(1);                                   // T
        adv(75);                                  // T+75
        chk("rst_pre_duty", 32'(d1_duty), 3);
        reset = 1'b1;
        #1;
        chk("arst_duty", 32'(d1_duty), 0);
        chk("arst_en",   32'(d1_en),   0);
        chk("arst_busy", 32'(d1_busy), 0);
        chk("arst_done", 32'(d1_done), 0);
        adv(1);
        reset = 1'b0;
        i_stop = 1'b0;
        i_duty_start = 8'd6;
        adv(1);
        chk("post_rst_duty", 32'(d1_duty), 6);
        chk("post_rst_en",   32'(d1_en),   1);
        chk("post_rst_busy", 32'(d1_busy), 0);
        i_duty_start = 8'd0;
        adv(1);
        chk("post_rst_zero_en", 32'(d1_en), 0);

        // Fault mid-ramp
        i_duty_start = 8'd4;
        adv(1);
        i_stop = 1'b1;
        adv(1);                                   // T
        adv(30);                                  // T+30
        i_fault = 1'b1;
        adv(1);                                   // T+31
`ifdef SOFT_STOP_FAULT_EN
        chk("fault_duty", 32'(d1_duty), 0);
        chk("fault_done", 32'(d1_done), 1);
        chk("fault_en",   32'(d1_en),   0);
        chk("fault_busy", 32'(d1_busy), 0);
        i_fault = 1'b0;
        adv(1);
        chk("fault_hold", 32'(d1_done), 1);
`else
        chk("nofault_duty", 32'(d1_duty), 4);
        chk("nofault_busy", 32'(d1_busy), 1);
        i_fault = 1'b0;
        adv(19);                                  // T+50
        chk("nofault_T50", 32'(d1_duty), 3);
`endif
        i_stop = 1'b0;
        adv(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
